// File: rtl/t_latch.sv
// Clocked toggle register: WIDTH independent T bits with shared enable and
// synchronous active-high reset; qb is the registered state inverted.
module t_latch #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] t,
   input  logic             en,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] qb
);

   // Declaration initialiser gives a defined all-zero state before the first reset.
   logic [WIDTH-1:0] q_q = '0;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (en) begin
         q_d = q_q ^ t;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q  = q_q;
   assign qb = ~q_q;

endmodule

// File: tb/tb_t_latch.sv
// Directed bench for t_latch (WIDTH=4): vector table plus hand-written
// between-edge sequences; qb == ~q is checked on every falling edge.
module tb_t_latch;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en  = 1'b0;
   logic [W-1:0] t   = '0;
   logic [W-1:0] q;
   logic [W-1:0] qb;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string        name;
      logic         rst;
      logic         en;
      logic [W-1:0] t;
      logic [W-1:0] q;
   } vec_t;

   vec_t vecs[$];

   t_latch #(.WIDTH(W)) dut (
      .clk(clk),
      .rst(rst),
      .t  (t),
      .en (en),
      .q  (q),
      .qb (qb)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Complement invariant, sampled away from the active edge.
   always @(negedge clk) begin
      check("qb_inv", qb, ~q);
   end

   task automatic apply(input string name, input logic r, input logic e, input logic [W-1:0] tv,
                        input logic [W-1:0] exp_q);
      @(negedge clk);
      rst = r;
      en  = e;
      t   = tv;
      @(posedge clk);
      #1;
      check({name, "_q"}, q, exp_q);
      check({name, "_qb"}, qb, ~exp_q);
   endtask

   logic [W-1:0] hold_q;

   initial begin
      // Power-up value before any edge
      #1;
      check("powerup_q", q, 4'b0000);
      check("powerup_qb", qb, 4'b1111);

      vecs.push_back('{"rst_hold1",    1'b1, 1'b0, 4'b0000, 4'b0000});
      vecs.push_back('{"rst_hold2",    1'b1, 1'b1, 4'b1111, 4'b0000});
      vecs.push_back('{"tog1",         1'b0, 1'b1, 4'b0001, 4'b0001});
      vecs.push_back('{"tog2",         1'b0, 1'b1, 4'b0001, 4'b0000});
      vecs.push_back('{"tog3",         1'b0, 1'b1, 4'b0001, 4'b0001});
      vecs.push_back('{"rst_win_t0",   1'b1, 1'b1, 4'b0000, 4'b0000});
      vecs.push_back('{"tog4",         1'b0, 1'b1, 4'b0001, 4'b0001});
      vecs.push_back('{"rst_win_t1",   1'b1, 1'b1, 4'b0001, 4'b0000});
      vecs.push_back('{"tog_from0",    1'b0, 1'b1, 4'b0001, 4'b0001});
      vecs.push_back('{"rst_again",    1'b1, 1'b0, 4'b0000, 4'b0000});
      vecs.push_back('{"hold_t0_a",    1'b0, 1'b1, 4'b0000, 4'b0000});
      vecs.push_back('{"hold_t0_b",    1'b0, 1'b1, 4'b0000, 4'b0000});
      vecs.push_back('{"set_one",      1'b0, 1'b1, 4'b0001, 4'b0001});
      vecs.push_back('{"en0_a",        1'b0, 1'b0, 4'b0001, 4'b0001});
      vecs.push_back('{"en0_b",        1'b0, 1'b0, 4'b1111, 4'b0001});
      vecs.push_back('{"en0_c",        1'b0, 1'b0, 4'b0001, 4'b0001});
      vecs.push_back('{"rst_wide",     1'b1, 1'b1, 4'b1111, 4'b0000});
      vecs.push_back('{"wide_1010",    1'b0, 1'b1, 4'b1010, 4'b1010});
      vecs.push_back('{"wide_0110",    1'b0, 1'b1, 4'b0110, 4'b1100});
      vecs.push_back('{"wide_1111",    1'b0, 1'b1, 4'b1111, 4'b0011});

      foreach (vecs[i]) begin
         apply(vecs[i].name, vecs[i].rst, vecs[i].en, vecs[i].t, vecs[i].q);
      end

      // Between-edge activity must not reach q (state 0011 here).
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b0;
      t   = 4'b0000;
      hold_q = 4'b0011;
      #1 t = 4'b1111;
      #1 check("mid_t_pulse", q, hold_q);
      en = 1'b1;
      #1 check("mid_en_pulse", q, hold_q);
      rst = 1'b1;
      #1 check("mid_rst_pulse", q, hold_q);
      rst = 1'b0;
      en  = 1'b0;
      t   = 4'b0000;
      @(posedge clk);
      #1;
      check("after_pulses_q", q, hold_q);
      check("after_pulses_qb", qb, ~hold_q);

      // rst raised between edges and still high at the edge: clears then.
      @(negedge clk);
      en = 1'b1;
      t  = 4'b1111;
      #2 rst = 1'b1;
      #1 check("rst_pre_edge", q, hold_q);
      @(posedge clk);
      #1;
      check("rst_at_edge", q, 4'b0000);
      // Release reset: first edge toggles from zero.
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_tog", q, 4'b1111);
      @(posedge clk);
      #1;
      check("post_rst_tog2", q, 4'b0000);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
